// File: rtl/word_tokenizer_pkg.sv
// Shared types and constants for the word tokenizer.
// Keyword spelling lives here so the FSM and classifier agree.
package word_tokenizer_pkg;

    typedef enum logic [1:0] {
        TOK_OTHER = 2'd0,
        TOK_BEGIN = 2'd1,
        TOK_END   = 2'd2
    } tok_kind_e;

    typedef enum logic [1:0] {
        S_SKIP  = 2'd0,
        S_MATCH = 2'd1,
        S_OTHER = 2'd2
    } state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    localparam logic [2:0] BEGIN_LEN = 3'd5;
    localparam logic [2:0] END_LEN   = 3'd3;

    function automatic logic [2:0] kw_len(input logic is_end);
        return is_end ? END_LEN : BEGIN_LEN;
    endfunction

    // Expected lower-case letter at position idx of the candidate keyword.
    function automatic logic [7:0] kw_char(input logic is_end,
                                           input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        if (is_end) begin
            case (idx)
                3'd0:    c = 8'h65;
                3'd1:    c = 8'h6E;
                3'd2:    c = 8'h64;
                default: c = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    c = 8'h62;
                3'd1:    c = 8'h65;
                3'd2:    c = 8'h67;
                3'd3:    c = 8'h69;
                3'd4:    c = 8'h6E;
                default: c = 8'h00;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/word_tokenizer_char_class.sv
// Character classifier: A-Z folding and delimiter detection.
// Define WORD_TOKENIZER_WS_EN to also treat TAB, LF and CR as delimiters.
module char_class
    import word_tokenizer_pkg::*;
(
    input  logic [7:0] ch,
    output logic [7:0] folded,
    output logic       delim
);

    always_comb begin
        folded = ch;
        if (ch >= 8'h41 && ch <= 8'h5A) folded = ch | 8'h20;
`ifdef WORD_TOKENIZER_WS_EN
        delim = (ch == CH_SPACE) || (ch == CH_TAB) ||
                (ch == CH_LF) || (ch == CH_CR);
`else
        delim = (ch == CH_SPACE);
`endif
    end

endmodule

// File: rtl/word_tokenizer.sv
// Streams ASCII characters into BEGIN/END/OTHER word tokens.
// Token outputs are registered and pulse for one cycle per word.
module word_tokenizer
    import word_tokenizer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       in_valid,
    input  logic       flush,
    output logic       tok_valid,
    output logic [1:0] tok_kind,
    output logic [7:0] tok_len
);

    state_e     state, state_n;
    logic       cand, cand_n;
    logic [2:0] idx, idx_n;
    logic [7:0] len, len_n;
    logic       tok_valid_n;
    tok_kind_e  tok_kind_n;
    logic [7:0] tok_len_n;

    logic [7:0] folded;
    logic       delim;
    logic       word_ch;
    logic       term;

    char_class u_class (
        .ch     (in),
        .folded (folded),
        .delim  (delim)
    );

    assign word_ch = in_valid && !delim;
    assign term    = flush || (in_valid && delim);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_SKIP;
            cand      <= 1'b0;
            idx       <= 3'd0;
            len       <= 8'd0;
            tok_valid <= 1'b0;
            tok_kind  <= 2'd0;
            tok_len   <= 8'd0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            idx       <= idx_n;
            len       <= len_n;
            tok_valid <= tok_valid_n;
            tok_kind  <= tok_kind_n;
            tok_len   <= tok_len_n;
        end
    end

    always_comb begin
        state_n     = state;
        cand_n      = cand;
        idx_n       = idx;
        len_n       = len;
        tok_valid_n = 1'b0;
        tok_kind_n  = TOK_OTHER;
        tok_len_n   = 8'd0;

        // Append the character first so flush+char ends the grown word.
        if (word_ch) begin
            if (state == S_SKIP) len_n = 8'd1;
            else if (len != 8'hFF) len_n = len + 8'd1;
            case (state)
                S_SKIP: begin
                    if (folded == 8'h62) begin
                        state_n = S_MATCH;
                        cand_n  = 1'b0;
                        idx_n   = 3'd1;
                    end else if (folded == 8'h65) begin
                        state_n = S_MATCH;
                        cand_n  = 1'b1;
                        idx_n   = 3'd1;
                    end else begin
                        state_n = S_OTHER;
                    end
                end
                S_MATCH: begin
                    if (idx < kw_len(cand) &&
                        folded == kw_char(cand, idx))
                        idx_n = idx + 3'd1;
                    else
                        state_n = S_OTHER;
                end
                default: state_n = S_OTHER;
            endcase
        end

        if (term && state_n != S_SKIP) begin
            tok_valid_n = 1'b1;
            tok_len_n   = len_n;
            if (state_n == S_MATCH && idx_n == kw_len(cand_n))
                tok_kind_n = cand_n ? TOK_END : TOK_BEGIN;
            state_n = S_SKIP;
            idx_n   = 3'd0;
            len_n   = 8'd0;
        end
    end

endmodule

// File: tb/tb_word_tokenizer.sv
// Self-checking bench for word_tokenizer: fixed vectors, corner
// sequences and random traffic against a string-level word model.
module tb_word_tokenizer;

    logic       clk;
    logic       reset;
    logic [7:0] in;
    logic       in_valid;
    logic       flush;
    logic       tok_valid;
    logic [1:0] tok_kind;
    logic [7:0] tok_len;

    word_tokenizer dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .flush     (flush),
        .tok_valid (tok_valid),
        .tok_kind  (tok_kind),
        .tok_len   (tok_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: current word (first 6 folded chars) and length
    string word = "";
    int    wlen = 0;

    int tok_cnt   = 0;
    int last_kind = -1;
    int last_len  = -1;

    typedef struct {
        string text;
        bit    flush_last;
        int    n;
        int    kind;
        int    len;
    } vec_t;

    vec_t vecs[8];

    function automatic bit is_delim(input byte c);
`ifdef WORD_TOKENIZER_WS_EN
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
`else
        return c == 8'h20;
`endif
    endfunction

    function automatic byte lc(input byte c);
        if (c >= "A" && c <= "Z") return c + 8'd32;
        return c;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input byte c, input bit v, input bit f);
        bit d, wc, ev, ev_tok;
        int ek, el;
        d  = is_delim(c);
        wc = v && !d;
        ev = f || (v && d);
        if (wc) begin
            wlen++;
            if (word.len() < 6) word = $sformatf("%s%c", word, lc(c));
        end
        ev_tok = 0;
        ek = 0;
        el = 0;
        if (ev && wlen > 0) begin
            ev_tok = 1;
            el = (wlen > 255) ? 255 : wlen;
            ek = (word == "begin") ? 1 : (word == "end") ? 2 : 0;
            wlen = 0;
            word = "";
        end
        in = c;
        in_valid = v;
        flush = f;
        @(posedge clk);
        #1;
        if (tok_valid) begin
            tok_cnt++;
            last_kind = int'(tok_kind);
            last_len  = int'(tok_len);
        end
        checks++;
        if ({tok_valid, tok_kind, tok_len} !== {ev_tok, 2'(ek), 8'(el)}) begin
            errors++;
            $display("FAIL cycle t=%0t: got v=%0d k=%0d l=%0d, expected v=%0d k=%0d l=%0d",
                     $time, tok_valid, tok_kind, tok_len, ev_tok, ek, el);
        end
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
    endtask

    // Pulse reset for 3 ns between edges; outputs must clear at once.
    task automatic pulse_reset(input string name);
        #1 reset = 1'b1;
        #1;
        chk({name, "_valid"}, int'(tok_valid), 0);
        chk({name, "_kind"}, int'(tok_kind), 0);
        chk({name, "_len"}, int'(tok_len), 0);
        #2 reset = 1'b0;
        word = "";
        wlen = 0;
    endtask

    initial begin
        string alpha;
        reset = 1'b1;
        in = 8'h00;
        in_valid = 1'b0;
        flush = 1'b0;
        #3;
        chk("reset_valid", int'(tok_valid), 0);
        chk("reset_kind", int'(tok_kind), 0);
        chk("reset_len", int'(tok_len), 0);
        #9 reset = 1'b0;

        vecs[0] = '{"bEgIN ", 1'b0, 1, 1, 5};
        vecs[1] = '{"enD  end ", 1'b0, 2, 2, 3};
        vecs[2] = '{"begi ", 1'b0, 1, 0, 4};
        vecs[3] = '{"beginx ", 1'b0, 1, 0, 6};
        vecs[4] = '{"end", 1'b1, 1, 2, 3};
        vecs[5] = '{"x ", 1'b1, 1, 0, 1};
`ifdef WORD_TOKENIZER_WS_EN
        vecs[6] = '{"end\t", 1'b0, 1, 2, 3};
`else
        vecs[6] = '{"end\t", 1'b0, 0, 0, 0};
`endif
        vecs[7] = '{"  b3gin ", 1'b0, 1, 0, 5};

        for (int v = 0; v < 8; v++) begin
            tok_cnt = 0;
            last_kind = -1;
            last_len = -1;
            for (int i = 0; i < vecs[v].text.len(); i++)
                step(vecs[v].text[i], 1'b1,
                     vecs[v].flush_last && i == vecs[v].text.len() - 1);
            chk($sformatf("vec%0d_count", v), tok_cnt, vecs[v].n);
            if (vecs[v].n > 0) begin
                chk($sformatf("vec%0d_kind", v), last_kind, vecs[v].kind);
                chk($sformatf("vec%0d_len", v), last_len, vecs[v].len);
            end
            step(8'h00, 1'b0, 1'b1);
            step(8'h00, 1'b0, 1'b0);
        end

        tok_cnt = 0;
        for (int i = 0; i < 300; i++) step("x", 1'b1, 1'b0);
        chk("long_count_before", tok_cnt, 0);
        step(" ", 1'b1, 1'b0);
        chk("long_kind", last_kind, 0);
        chk("long_len", last_len, 255);

        tok_cnt = 0;
        feed("x ");
        pulse_reset("reset_async");
        feed("be");
        pulse_reset("reset_midword");
        tok_cnt = 0;
        feed("end ");
        chk("after_reset_count", tok_cnt, 1);
        chk("after_reset_kind", last_kind, 2);
        chk("after_reset_len", last_len, 3);

        alpha = "bBeEgGiInNdDx \t\r";
        for (int i = 0; i < 3000; i++)
            step(alpha[$urandom_range(0, alpha.len() - 1)],
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
